pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
// - Next-generation program counter for the MIPS core. Holds the fetch address, applies J/JAL, JR/JALR and branch redirects.
// - Implements architectural branch-delay-slot semantics. The instruction after a taken control transfer always executes.
// - Detects program exit and counts retired instructions.
// - Sits in the controlpath between the decoder/branch resolver and instruction memory.
// PARAMETERS
// - ADDR_W        32            address width; legal range 28..32
// - RESET_VECTOR  32'hBFC00000  pc value after reset, truncated to ADDR_W
// - EXIT_ADDR     0             loading this address ends execution
// - CNT_W         32            width of retired-instruction counter
// PORTS
// - clk            in   1       clock, rising edge
// - reset          in   1       synchronous, active-high
// - advance        in   1       end of EXEC; commit current instruction
// - stall          in   1       freeze all state; overrides advance
// - redirect_kind  in   2       00 none, 01 register (JR/JALR), 10 page jump (J/JAL), 11 PC-relative branch (taken)
// - instr_index    in   26      J-type target field
// - imm16          in   16      branch offset field
// - reg_target     in   ADDR_W  rs value for JR/JALR
// - pc             out  ADDR_W  address of instruction currently executing
// - link_addr      out  ADDR_W  pc+8; write-back value for JAL/JALR/BxxAL
// - delay_slot     out  1       current instruction is a delay slot
// - finish         out  1       execution has ended
// - retired        out  CNT_W   accepted-advance count
// BEHAVIOUR
// - Accept: an advance with stall=0 and state!=HALT. No other event changes pc, state, pending or retired.
// - States:
//   - RUN: no transfer pending.
//   - SLOT: target latched; the delay-slot instruction is executing.
//   - HALT: terminal.
// - Reset values: state=RUN, pc=RESET_VECTOR, pending_target=0, delay_slot=0, finish=0, retired=0.
//   - Reset has priority over every other input.
//   - Reset mid-SLOT discards the pending target.
// - Target calculation happens on an accepted advance in RUN with redirect_kind!=00. All arithmetic is mod 2^ADDR_W.
//   - 01: target = reg_target.
//   - 10: target = {(pc+4)[ADDR_W-1:28], instr_index, 2'b00}.
//   - 11: target = pc + 4 + (sign_extend(imm16) << 2).
//   - The target is latched, then pc <= pc+4 and state RUN->SLOT.
// - RUN, accept, redirect_kind=00: pc <= pc+4.
// - SLOT, accept: pc <= pending_target, then state -> RUN. redirect_kind is ignored; branch in a delay slot is defined as no-op redirect.
// - After any accepted pc update, if new pc == EXIT_ADDR: state -> HALT.
// - HALT behaviour:
//   - finish=1; pc holds EXIT_ADDR.
//   - advance is ignored and retired is frozen.
//   - Only reset leaves HALT.
// - Output timing and wrap rules:
//   - delay_slot = (state==SLOT), registered.
//   - link_addr is combinational pc+8.
//   - retired increments by 1 per accept and wraps at 2^CNT_W.
//   - pc+4 wraps at 2^ADDR_W with no error.
// - Latency: pc, delay_slot, finish and retired change on the clock edge of the accept.
// - stall=1 with advance=1 in the same cycle: nothing changes.
// CONFIGURATION
// - ADDR_ERR_EN defined:
//   - Extra output addr_err (1). Reset value 0; sticky until reset.
//   - If a value with bits[1:0]!=0 would be loaded into pc, addr_err <= 1 and state -> HALT.
//   - In that case pc is not updated, finish=1 and retired still increments for that accept.
//   - A misaligned reg_target is checked when it is loaded from SLOT, not when it is latched.
// - ADDR_ERR_EN undefined: no addr_err port; register targets are loaded with bits[1:0] forced to 00.
// TESTING
// - Reset, then 3 accepts, redirect 00 -> pc BFC00000, BFC00004, BFC00008, BFC0000C; retired=3; delay_slot=0 throughout.
// - At pc=BFC00010, branch imm16=FFFE -> pc BFC00014 with delay_slot=1; next accept -> pc BFC0000C, delay_slot=0.
// - At pc=BFC00020, J instr_index=0000100 -> slot BFC00024, then pc B0000400; link_addr at the jump = BFC00028.
// - JR reg_target=0 from BFC00030 -> slot BFC00034, then pc 0, finish=1. Further advances leave pc=0 and retired unchanged.
// - stall=1 with advance=1 for 4 cycles in SLOT -> state, pc and retired frozen; reset in SLOT -> pc BFC00000, delay_slot=0, pending target discarded.
// - ADDR_ERR_EN: JR reg_target=BFC00102 -> after the slot, addr_err=1, finish=1, pc stays at the slot address.
//   Undefined: the same stimulus -> pc BFC00100.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter with branch-delay-slot sequencing, exit detection and retired count.
// Optional ADDR_ERR_EN adds a sticky addr_err output for misaligned register targets.
module pc_sequencer #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXIT_ADDR    = 32'h0,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              stall,
    input  logic [1:0]        redirect_kind,
    input  logic [25:0]       instr_index,
    input  logic [15:0]       imm16,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              delay_slot,
    output logic              finish,
`ifdef ADDR_ERR_EN
    output logic              addr_err,
`endif
    output logic [CNT_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] RST_PC  = RESET_VECTOR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXIT_PC = EXIT_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {RUN, SLOT, HALT} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pend, pend_nxt, pc_nxt;
    logic [CNT_W-1:0]    ret_nxt;
    logic [ADDR_W-1:0]   pc_plus4, jump_tgt, br_off, reg_tgt, target, load_val;
    logic                accept, load;
`ifdef ADDR_ERR_EN
    logic                err_nxt;
`endif

    assign accept    = advance && !stall && (state != HALT);
    assign pc_plus4  = pc + ADDR_W'(4);
    assign link_addr = pc + ADDR_W'(8);
    // Page jump keeps the top nibble of pc+4; masking also covers ADDR_W == 28.
    assign jump_tgt  = (pc_plus4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({instr_index, 2'b00});
    assign br_off    = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
`ifdef ADDR_ERR_EN
    assign reg_tgt   = reg_target;
`else
    assign reg_tgt   = reg_target & ~ADDR_W'(3);
`endif

    always_comb begin
        case (redirect_kind)
            2'b01:   target = reg_tgt;
            2'b10:   target = jump_tgt;
            2'b11:   target = pc_plus4 + br_off;
            default: target = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        ret_nxt   = retired;
        load      = 1'b0;
        load_val  = pc_plus4;
`ifdef ADDR_ERR_EN
        err_nxt   = addr_err;
`endif
        if (accept) begin
            ret_nxt = retired + CNT_W'(1);
            case (state)
                RUN: begin
                    load = 1'b1;
                    if (redirect_kind != 2'b00) begin
                        pend_nxt  = target;
                        state_nxt = SLOT;
                    end
                end
                SLOT: begin
                    load      = 1'b1;
                    load_val  = pend;
                    state_nxt = RUN;
                end
                default: ;
            endcase
            if (load) begin
`ifdef ADDR_ERR_EN
                if (load_val[1:0] != 2'b00) begin
                    err_nxt   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    pc_nxt = load_val;
                    if (load_val == EXIT_PC) state_nxt = HALT;
                end
`else
                pc_nxt = load_val;
                if (load_val == EXIT_PC) state_nxt = HALT;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RST_PC;
            pend    <= '0;
            retired <= '0;
`ifdef ADDR_ERR_EN
            addr_err <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend    <= pend_nxt;
            retired <= ret_nxt;
`ifdef ADDR_ERR_EN
            addr_err <= err_nxt;
`endif
        end
    end

    assign delay_slot = (state == SLOT);
    assign finish     = (state == HALT);

endmodule
